data_cache_wb: RTL and testbench

- Parametrised, direct-mapped, write-back, write-allocate data cache. Next generation of the processor's data-memory path.
- Sits between the MIPS MEM stage and main memory.
- Hits complete in the request cycle with no stall. Misses stall the CPU while a multi-word line is written back (if dirty) and refilled.
- Memory side is a per-word req/ready handshake with arbitrary memory latency.

---
 rtl/data_cache_pkg.sv | 16 +
 rtl/data_cache_wb_if.sv | 23 ++
 rtl/cache_line_store.sv | 60 ++++++
 rtl/data_cache_wb.sv | 124 ++++++++++++
 tb/tb_data_cache_wb.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared FSM encoding and address-geometry helpers for the data cache
package data_cache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESUME} state_e;
  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - idx_w(sets) - off_w(line_words) - 2;
  endfunction
  function automatic int cnt_w(input int line_words);
    return line_words > 1 ? off_w(line_words) : 1;
  endfunction
endpackage

// File: rtl/data_cache_wb_if.sv
// data_cache_wb_if: CPU-side and memory-side buses of the data cache
interface data_cache_wb_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_rdata, mem_ready,
    output cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_read, mem_write
  );
  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/cache_line_store.sv
// cache_line_store: tag/valid/dirty/data arrays with async read and per-word sync write
module cache_line_store
  import data_cache_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 26,
  parameter int IDX_W      = 4,
  parameter int CW         = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  r_idx,
  input  logic [CW-1:0]     r_off,
  output logic              r_valid,
  output logic              r_dirty,
  output logic [TAG_W-1:0]  r_tag,
  output logic [DATA_W-1:0] r_data,
  input  logic [IDX_W-1:0]  w_idx,
  input  logic [CW-1:0]     w_off,
  input  logic              w_en,
  input  logic              w_dirty,
  input  logic [DATA_W-1:0] w_data,
  input  logic              fill,
  input  logic [TAG_W-1:0]  fill_tag
);
  logic [SETS-1:0]   valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q [SETS];
  logic [DATA_W-1:0] data_q [SETS][LINE_WORDS];
  assign r_valid = valid_q[r_idx];
  assign r_dirty = dirty_q[r_idx];
  assign r_tag   = tag_q[r_idx];
  assign r_data  = data_q[r_idx][r_off];
  // a store marks its line dirty; a completed refill validates the line as clean
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (w_en && w_dirty) dirty_d[w_idx] = 1'b1;
    if (fill) begin
      valid_d[w_idx] = 1'b1;
      dirty_d[w_idx] = 1'b0;
    end
  end
  // line status bits; only these need clearing on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end
  // tag and data arrays hold garbage until a line is filled
  always_ff @(posedge clk) begin
    if (w_en) data_q[w_idx][w_off] <= w_data;
    if (fill) tag_q[w_idx] <= fill_tag;
  end
endmodule

// File: rtl/data_cache_wb.sv
// data_cache_wb: direct-mapped write-back write-allocate data cache with per-word memory handshake
module data_cache_wb
  import data_cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input logic             clk,
  input logic             rst,
  data_cache_wb_if.slave  bus
);
  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int CW    = cnt_w(LINE_WORDS);
  state_e            state_q, state_d;
  logic [CW-1:0]     k_q, k_d;
  logic [TAG_W-1:0]  vtag_q, vtag_d;
  logic [IDX_W-1:0]  vidx_q, vidx_d;
  logic [TAG_W-1:0]  req_tag, r_tag;
  logic [IDX_W-1:0]  req_idx, r_idx;
  logic [CW-1:0]     req_off, r_off, w_off;
  logic              r_valid, r_dirty, w_en, w_dirty, fill, hit, last, is_rd, is_wr;
  logic [DATA_W-1:0] r_data, w_data;
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i,
                                                  input logic [CW-1:0] k);
    return (ADDR_W'(t) << (IDX_W + OFF_W + 2)) | (ADDR_W'(i) << (OFF_W + 2)) | (ADDR_W'(k) << 2);
  endfunction
  assign req_idx = IDX_W'(bus.cpu_addr >> (OFF_W + 2));
  assign req_tag = TAG_W'(bus.cpu_addr >> (OFF_W + IDX_W + 2));
  assign req_off = LINE_WORDS > 1 ? CW'(bus.cpu_addr >> 2) : '0;
  assign is_wr   = bus.cpu_write;
  assign is_rd   = bus.cpu_read && !bus.cpu_write;
  assign hit     = r_valid && r_tag == req_tag;
  assign last    = k_q == CW'(LINE_WORDS - 1);
  // the store is read at the victim line while writing back, otherwise at the requested word
  always_comb begin
    r_idx = state_q == WRITEBACK ? vidx_q : req_idx;
    r_off = state_q == IDLE ? req_off : k_q;
  end
  cache_line_store #(
    .SETS(SETS), .LINE_WORDS(LINE_WORDS), .DATA_W(DATA_W), .TAG_W(TAG_W), .IDX_W(IDX_W), .CW(CW)
  ) u_store (
    .clk(clk), .rst(rst), .r_idx(r_idx), .r_off(r_off), .r_valid(r_valid), .r_dirty(r_dirty),
    .r_tag(r_tag), .r_data(r_data), .w_idx(req_idx), .w_off(w_off), .w_en(w_en), .w_dirty(w_dirty),
    .w_data(w_data), .fill(fill), .fill_tag(req_tag)
  );
  // lookup, miss handling and the word-by-word writeback/refill sequence
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    vtag_d        = vtag_q;
    vidx_d        = vidx_q;
    w_en          = 1'b0;
    w_dirty       = 1'b0;
    w_off         = req_off;
    w_data        = bus.cpu_wdata;
    fill          = 1'b0;
    bus.cpu_stall = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: if (is_rd || is_wr) begin
        if (hit) begin
          w_en          = is_wr;
          w_dirty       = is_wr;
          bus.cpu_rdata = is_rd ? r_data : '0;
        end else begin
          bus.cpu_stall = 1'b1;
          vtag_d        = r_tag;
          vidx_d        = req_idx;
          state_d       = r_valid && r_dirty ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        bus.cpu_stall = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = line_addr(vtag_q, vidx_q, k_q);
        bus.mem_wdata = r_data;
        if (bus.mem_ready) begin
          k_d     = last ? '0 : k_q + 1'b1;
          state_d = last ? REFILL : WRITEBACK;
        end
      end
      REFILL: begin
        bus.cpu_stall = 1'b1;
        bus.mem_read  = 1'b1;
        bus.mem_addr  = line_addr(req_tag, req_idx, k_q);
        w_off         = k_q;
        w_data        = bus.mem_rdata;
        if (bus.mem_ready) begin
          w_en    = 1'b1;
          fill    = last;
          k_d     = last ? '0 : k_q + 1'b1;
          state_d = last ? RESUME : REFILL;
        end
      end
      default: begin
        bus.cpu_stall = 1'b1;
        state_d       = IDLE;
      end
    endcase
    if (!rst) bus.cpu_stall = 1'b0;
  end
  // FSM state, word counter and latched victim address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      vtag_q  <= '0;
      vidx_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      vtag_q  <= vtag_d;
      vidx_q  <= vidx_d;
    end
  end
endmodule

// File: tb/tb_data_cache_wb.sv
// tb_data_cache_wb: directed scoreboard bench for data_cache_wb with a latency-programmable memory model
module tb_data_cache_wb;
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int mem_wait = 0;
  int wcnt = 0;
  logic have_prev = 1'b0;
  logic [31:0] prev_addr = '0;
  logic prev_rd = 1'b0;
  xfer_t exp_q[$];
  logic [31:0] mem_m [logic [31:0]];
  data_cache_wb_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  data_cache_wb #(.ADDR_W(32), .DATA_W(32), .SETS(16), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] init_w(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : init_w(a);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_line(input logic w, input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      xfer_t x;
      x.w = w;
      x.a = base + 32'(i * 4);
      x.d = w ? mem_m_shadow(x.a) : '0;
      exp_q.push_back(x);
    end
  endtask
  logic [31:0] shadow [logic [31:0]];
  function automatic logic [31:0] mem_m_shadow(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_w(a);
  endfunction
  // memory model: decides mem_ready after a programmable wait and scores every completed word
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      bus.mem_ready = 1'b0;
      wcnt = 0;
      have_prev = 1'b0;
    end else if (bus.mem_read || bus.mem_write) begin
      chk("mem_rw_excl", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
      if (have_prev) begin
        chk("mem_addr_stable", bus.mem_addr, prev_addr);
        chk("mem_read_stable", {31'd0, bus.mem_read}, {31'd0, prev_rd});
      end
      bus.mem_ready = wcnt >= mem_wait;
      bus.mem_rdata = bus.mem_read ? mem_rd(bus.mem_addr) : '0;
      if (bus.mem_ready) begin
        chk("mem_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          xfer_t x;
          x = exp_q.pop_front();
          chk("mem_kind", {31'd0, bus.mem_write}, {31'd0, x.w});
          chk("mem_addr", bus.mem_addr, x.a);
          if (x.w) chk("mem_wdata", bus.mem_wdata, x.d);
        end
        if (bus.mem_write) mem_m[bus.mem_addr] = bus.mem_wdata;
        wcnt = 0;
        have_prev = 1'b0;
      end else begin
        wcnt++;
        have_prev = 1'b1;
        prev_addr = bus.mem_addr;
        prev_rd = bus.mem_read;
      end
    end else begin
      bus.mem_ready = 1'b0;
      wcnt = 0;
      have_prev = 1'b0;
    end
  end
  // one CPU access; exp_stall counts every cycle with cpu_stall=1, the request cycle included
  task automatic op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input int exp_stall, input string tag);
    int n;
    @(negedge clk);
    bus.cpu_addr = a;
    bus.cpu_wdata = wd;
    bus.cpu_read = r;
    bus.cpu_write = w;
    #2;
    n = 0;
    while (bus.cpu_stall && n < 200) begin
      n++;
      @(negedge clk);
      #2;
    end
    chk({tag, "_stall"}, n, exp_stall);
    if (r) chk({tag, "_rdata"}, bus.cpu_rdata, exp_rd);
    chk({tag, "_memq"}, exp_q.size(), 0);
    @(negedge clk);
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
  endtask
  initial begin
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("rst_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    push_line(1'b0, 32'h100);
    op(1, 0, 32'h104, 0, init_w(32'h104), 6, "cold_read");
    op(0, 1, 32'h108, 32'hDEADBEEF, 0, 0, "write_hit");
    shadow[32'h108] = 32'hDEADBEEF;
    op(1, 0, 32'h108, 0, 32'hDEADBEEF, 0, "read_after_write");
    push_line(1'b1, 32'h100);
    push_line(1'b0, 32'h500);
    op(1, 0, 32'h504, 0, init_w(32'h504), 10, "conflict_read");
    op(1, 1, 32'h500, 32'h12345678, 32'd0, 0, "rw_hit");
    shadow[32'h500] = 32'h12345678;
    push_line(1'b1, 32'h500);
    push_line(1'b0, 32'h100);
    op(1, 0, 32'h108, 0, 32'hDEADBEEF, 10, "rw_dirty_evict");
    push_line(1'b0, 32'h080);
    op(0, 1, 32'h080, 32'hCAFEF00D, 0, 6, "write_miss");
    op(1, 0, 32'h080, 0, 32'hCAFEF00D, 0, "write_miss_read");
    mem_wait = 3;
    push_line(1'b0, 32'h030);
    op(1, 0, 32'h034, 0, init_w(32'h034), 18, "slow_miss");
    mem_wait = 0;
    exp_q.push_back('{1'b0, 32'h040, 32'h0});
    exp_q.push_back('{1'b0, 32'h044, 32'h0});
    @(negedge clk);
    bus.cpu_addr = 32'h044;
    bus.cpu_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("pre_rst_mem_read", {31'd0, bus.mem_read}, 32'd1);
    chk("pre_rst_mem_addr", bus.mem_addr, 32'h044);
    rst = 1'b0;
    #1;
    chk("mid_rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk("mid_rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("mid_rst_mem_addr", bus.mem_addr, 32'd0);
    chk("mid_rst_rdata", bus.cpu_rdata, 32'd0);
    @(negedge clk);
    bus.cpu_read = 1'b0;
    rst = 1'b1;
    chk("mid_rst_memq", exp_q.size(), 0);
    push_line(1'b0, 32'h040);
    op(1, 0, 32'h044, 0, init_w(32'h044), 6, "post_rst_miss");
    push_line(1'b0, 32'h100);
    op(1, 0, 32'h104, 0, init_w(32'h104), 6, "post_rst_idx0_miss");
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
